// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared opcodes, FSM state codes, datapath select codes and
//               the control-word layout for the multicycle MIPS controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

  // Opcodes (IR[31:26]) understood by the multicycle controller
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Main-control states; encodings 12..15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_REXEC   = 4'd6,
    S_RCOMP   = 4'd7,
    S_IEXEC   = 4'd8,
    S_ICOMP   = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  // ALU operation codes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B-operand selects
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Full set of datapath controls driven from one state
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_word_t;

endpackage
`default_nettype wire

// File: rtl/mc_output_decode.sv
`default_nettype none
// ============================================================================
// Module      : mc_output_decode
// Description : Pure state -> control-word decode for the multicycle main
//               control FSM (Moore outputs before handshake gating).
// Revision    : 1.0 - initial release
// ============================================================================
module mc_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  output ctrl_word_t ctrl
);

  // Each state drives only the controls it needs; everything else stays 0
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // Qualified with mem_ready at the top level
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADDR, S_IEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_REXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RCOMP: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
      end
      S_ICOMP: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Multicycle MIPS main-control FSM. Holds the state register,
//               next-state logic, memory-ready gating of fetch writes and
//               the reset override of every control output.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal_op
);

  state_t     state_q;
  state_t     state_d;
  ctrl_word_t ctrl;
  logic       decode_illegal;
  logic       fetch_wait;

  // State register; reset lands in FETCH on the first edge with rst high
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection; opcode is only looked at in DECODE and MEMADDR
  always_comb begin
    state_d        = S_FETCH;
    decode_illegal = 1'b0;
    case (state_q)
      S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_REXEC;
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_IEXEC;
          default: begin
            state_d        = S_FETCH;
            decode_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADDR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_REXEC:   state_d = S_RCOMP;
      S_RCOMP:   state_d = S_FETCH;
      S_IEXEC:   state_d = S_ICOMP;
      S_ICOMP:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  mc_output_decode u_output_decode (
    .state (state_q),
    .ctrl  (ctrl)
  );

  // IR and PC only load once the fetch read has actually returned
  assign fetch_wait = (state_q == S_FETCH) && !mem_ready;

  // Drive the datapath controls; reset forces every output low immediately
  always_comb begin
    PCWrite     = ctrl.pc_write & ~fetch_wait;
    PCWriteCond = ctrl.pc_write_cond;
    IorD        = ctrl.iord;
    MemRead     = ctrl.mem_read;
    MemWrite    = ctrl.mem_write;
    IRWrite     = ctrl.ir_write & ~fetch_wait;
    MemtoReg    = ctrl.mem_to_reg;
    RegDst      = ctrl.reg_dst;
    RegWrite    = ctrl.reg_write;
    ALUSrcA     = ctrl.alu_src_a;
    ALUSrcB     = ctrl.alu_src_b;
    ALUOp       = ctrl.alu_op;
    PCSource    = ctrl.pc_source;
    illegal_op  = decode_illegal;
    if (rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;
      illegal_op  = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Self-checking bench for multicycle_control. A per-instruction
//               reference model expands each instruction (with its memory
//               wait cycles) into the expected per-cycle control outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  // Expected/observed control outputs, one entry per clock cycle
  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       m2r;
    logic       rdst;
    logic       rw;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] aop;
    logic [1:0] pcs;
    logic       ill;
  } cw_t;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;

  int errors = 0;
  int checks = 0;

  // Per-cycle stimulus and expectations produced by the model
  logic       rdy_q[$];
  logic [5:0] op_q[$];
  cw_t        exp_q[$];

  multicycle_control dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .illegal_op  (illegal_op)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic cw_t observe();
    cw_t o;
    o = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
          RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};
    return o;
  endfunction

  function automatic logic known_op(input logic [5:0] op);
    return (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
           (op == 6'b000100) || (op == 6'b000010) || (op == 6'b001000);
  endfunction

  function automatic void push(input logic rdy, input logic [5:0] op, input cw_t e);
    rdy_q.push_back(rdy);
    op_q.push_back(op);
    exp_q.push_back(e);
  endfunction

  // Reference model: the instruction's step sequence from fetch to write-back.
  // Cycles without a memory access get random mem_ready, which must be ignored.
  function automatic void model_instr(input logic [5:0] op, input int fw, input int mw);
    cw_t e;
    logic r;
    // instruction fetch, stalled fw cycles
    for (int i = 0; i <= fw; i++) begin
      e = '0; e.mrd = 1; e.asb = 2'b01;
      r = (i == fw);
      e.irw = r; e.pcw = r;
      push(r, op, e);
    end
    // decode: branch target add; unknown opcode flags and ends here
    e = '0; e.asb = 2'b11; e.ill = !known_op(op);
    push(1'($urandom_range(0, 1)), op, e);
    if (op == 6'b000000) begin
      e = '0; e.asa = 1; e.asb = 2'b00; e.aop = 2'b10;
      push(1'($urandom_range(0, 1)), op, e);
      e = '0; e.rw = 1; e.rdst = 1;
      push(1'($urandom_range(0, 1)), op, e);
    end else if (op == 6'b100011 || op == 6'b101011) begin
      e = '0; e.asa = 1; e.asb = 2'b10;
      push(1'($urandom_range(0, 1)), op, e);
      for (int i = 0; i <= mw; i++) begin
        e = '0; e.iord = 1;
        if (op == 6'b100011) e.mrd = 1; else e.mwr = 1;
        push(i == mw, op, e);
      end
      if (op == 6'b100011) begin
        e = '0; e.rw = 1; e.m2r = 1;
        push(1'($urandom_range(0, 1)), op, e);
      end
    end else if (op == 6'b000100) begin
      e = '0; e.asa = 1; e.aop = 2'b01; e.pcwc = 1; e.pcs = 2'b01;
      push(1'($urandom_range(0, 1)), op, e);
    end else if (op == 6'b000010) begin
      e = '0; e.pcw = 1; e.pcs = 2'b10;
      push(1'($urandom_range(0, 1)), op, e);
    end else if (op == 6'b001000) begin
      e = '0; e.asa = 1; e.asb = 2'b10;
      push(1'($urandom_range(0, 1)), op, e);
      e = '0; e.rw = 1;
      push(1'($urandom_range(0, 1)), op, e);
    end
  endfunction

  // All outputs low for three cycles of reset regardless of inputs
  task automatic test_reset();
    cw_t o;
    rst = 1'b1; opcode = 6'b0; mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      opcode = 6'($urandom); mem_ready = 1'($urandom);
      @(negedge clk);
      o = observe(); checks++;
      if (o !== cw_t'(0)) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d: got %h expected %h", c, o, cw_t'(0));
      end
    end
  endtask

  // R-type straight out of reset: FETCH, DECODE, REXEC, RCOMP
  task automatic test_rtype();
    cw_t o, e;
    int c = 0;
    model_instr(6'b000000, 0, 0);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      rst = 1'b0; mem_ready = rdy_q.pop_front(); opcode = op_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      o = observe(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rtype cyc%0d: got %h expected %h", c, o, e);
      end
      c++;
    end
  endtask

  // LW with 2 fetch stalls and 1 read stall: 8 cycles
  task automatic test_lw_wait();
    cw_t o, e;
    int c = 0;
    model_instr(6'b100011, 2, 1);
    if (exp_q.size() != 8) begin
      errors++;
      $display("FAIL lw_len: got %0d expected 8", exp_q.size());
    end
    checks++;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      mem_ready = rdy_q.pop_front(); opcode = op_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      o = observe(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL lw_wait cyc%0d: got %h expected %h", c, o, e);
      end
      c++;
    end
  endtask

  // SW with no stalls: 4 cycles, never RegWrite
  task automatic test_sw();
    cw_t o, e;
    int c = 0;
    model_instr(6'b101011, 0, 0);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      mem_ready = rdy_q.pop_front(); opcode = op_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      o = observe(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL sw cyc%0d: got %h expected %h", c, o, e);
      end
      c++;
    end
  endtask

  // BEQ followed immediately by J, then illegal opcode then ADDI
  task automatic test_back_to_back();
    cw_t o, e;
    int c = 0;
    model_instr(6'b000100, 0, 0);
    model_instr(6'b000010, 0, 0);
    model_instr(6'b111111, 0, 0);
    model_instr(6'b001000, 0, 0);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      mem_ready = rdy_q.pop_front(); opcode = op_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      o = observe(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL back_to_back cyc%0d: got %h expected %h", c, o, e);
      end
      c++;
    end
  endtask

  // Random instruction mix with random memory stalls
  task automatic test_random();
    cw_t o, e;
    logic [5:0] ops [7];
    int c = 0;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b0};
    for (int n = 0; n < 40; n++) begin
      logic [5:0] op;
      int k;
      k = int'($urandom_range(0, 6));
      op = (k == 6) ? 6'($urandom) : ops[k];
      model_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      mem_ready = rdy_q.pop_front(); opcode = op_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      o = observe(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL random cyc%0d op=%b: got %h expected %h", c, opcode, o, e);
      end
      c++;
    end
  endtask

  // Reset during a stalled store kills MemWrite at once; fetch resumes after
  task automatic test_reset_midwrite();
    cw_t o, e;
    int c = 0;
    model_instr(6'b101011, 0, 3);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      mem_ready = rdy_q.pop_front(); opcode = op_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      o = observe(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL midwrite_pre cyc%0d: got %h expected %h", i, o, e);
      end
    end
    rdy_q.delete(); op_q.delete(); exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    o = observe(); checks++;
    if (o !== cw_t'(0)) begin
      errors++;
      $display("FAIL midwrite_rst: got %h expected %h", o, cw_t'(0));
    end
    model_instr(6'b001000, 1, 0);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      rst = 1'b0; mem_ready = rdy_q.pop_front(); opcode = op_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      o = observe(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL midwrite_resume cyc%0d: got %h expected %h", c, o, e);
      end
      c++;
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw();
    test_back_to_back();
    test_random();
    test_reset_midwrite();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
